// File: rtl/sat_cnt_arbiter_pkg.sv
// Shared types and constants for the saturating-counter arbiter.
// The stage counter width and its saturation value live here.
package sat_cnt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

endpackage

// File: rtl/sat_cnt_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// state_dbg mirrors the arbiter FSM state for observation.
interface sat_cnt_arbiter_if #(
    parameter int NREQ = 3
);
    import sat_cnt_arbiter_pkg::*;

    // req[i] is a level request held for the whole transaction; gnt is
    // one-hot while the owner runs and done pulses once when a sequence ends.
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [1:0]       owner;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    state_e           state_dbg;

    modport master (
        output req,
        input  gnt, owner, cnt, busy, done, state_dbg
    );

    modport slave (
        input  req,
        output gnt, owner, cnt, busy, done, state_dbg
    );

endinterface

// File: rtl/sat_cnt_arbiter_stage_cnt.sv
// Shared 2-bit stage counter: clear beats enable, and counting stops at CNT_MAX.
module stage_cnt
    import sat_cnt_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sat_cnt_arbiter.sv
// Round-robin arbiter handing a shared saturating stage counter to one
// requester at a time: IDLE -> RUN (count 0..3) -> DONE -> IDLE.
module sat_cnt_arbiter
    import sat_cnt_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    sat_cnt_arbiter_if.slave   bus
);

    localparam logic [1:0] LAST_RST = 2'(NREQ - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_val;

    logic            found;
    logic [1:0]      win;
    logic            owner_req;

    stage_cnt u_stage_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_val),
        .full  (cnt_full)
    );

    // Round-robin search starting just after the most recent grantee.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
    end

    // gnt_q is one-hot on the owner during RUN, so this picks req[owner].
    assign owner_req = |(bus.req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                gnt_d   = '0;
                if (found) begin
                    state_d = RUN;
                    owner_d = win;
                    last_d  = win;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (win == 2'(i));
                    end
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_clr = 1'b1;
                end else if (cnt_full) begin
                    state_d = DONE;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.cnt       = cnt_val;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sat_cnt_arbiter.sv
// Bench for sat_cnt_arbiter: directed scenarios plus random traffic, each
// cycle compared against a transaction-age reference model.
module tb_sat_cnt_arbiter;
    import sat_cnt_arbiter_pkg::*;

    localparam int NREQ  = 3;
    localparam int EXP_W = 8 + NREQ;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sat_cnt_arbiter_if #(.NREQ(NREQ)) bus ();

    sat_cnt_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: age -1 = idle, 0..3 = running with cnt=age, 4 = done cycle.
    int m_age   = -1;
    int m_owner = 0;
    int m_last  = NREQ - 1;
    logic [EXP_W-1:0] exp_q[$];
    logic prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step(input logic rst, input logic [NREQ-1:0] r);
        logic [1:0]      st;
        logic [1:0]      c;
        logic [NREQ-1:0] g;
        if (rst) begin
            m_age   = -1;
            m_owner = 0;
            m_last  = NREQ - 1;
        end else if (m_age < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_last + k) % NREQ;
                if (m_age < 0 && r[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_age   = 0;
                end
            end
        end else if (m_age <= 3) begin
            if (!r[m_owner])      m_age = -1;
            else if (m_age == 3)  m_age = 4;
            else                  m_age = m_age + 1;
        end else begin
            m_age = -1;
        end
        st = (m_age < 0) ? IDLE : (m_age == 4) ? DONE : RUN;
        c  = (m_age < 0) ? 2'd0 : (m_age == 4) ? 2'd3 : 2'(m_age);
        g  = '0;
        if (m_age >= 0 && m_age <= 3) g[m_owner] = 1'b1;
        exp_q.push_back({st, 2'(m_owner), c, (m_age >= 0), (m_age == 4), g});
    endfunction

    task automatic compare_outputs();
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("state", bus.state_dbg, e[EXP_W-1 -: 2]);
        check("owner", bus.owner,     e[EXP_W-3 -: 2]);
        check("cnt",   bus.cnt,       e[EXP_W-5 -: 2]);
        check("busy",  bus.busy,      e[NREQ+1]);
        check("done",  bus.done,      e[NREQ]);
        check("gnt",   bus.gnt,       e[NREQ-1:0]);
        check("gnt_onehot0", $onehot0(bus.gnt), 1);
        check("done_twice", prev_done & bus.done, 0);
        check("busy_vs_state", bus.busy, bus.state_dbg != IDLE);
        prev_done = bus.done;
    endtask

    task automatic cycle(input logic rst, input logic [NREQ-1:0] r);
        reset   = rst;
        bus.req = r;
        @(posedge clk);
        model_step(rst, r);
        @(negedge clk);
        compare_outputs();
    endtask

    int rr_owner[$];
    int done_seen;

    initial begin
        logic [NREQ-1:0] r;
        logic            rst;
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);

        // Reset state
        cycle(1'b1, 3'b000);
        check("rst_gnt", bus.gnt, 3'b000);
        check("rst_owner", bus.owner, 0);

        // Single requester: grant, count 0..3, done, idle, re-grant
        cycle(1'b0, 3'b001);
        check("single_gnt", bus.gnt, 3'b001);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 3'b001);
            check("single_cnt", bus.cnt, 32'(i));
        end
        cycle(1'b0, 3'b001);
        check("single_done", bus.done, 1);
        check("single_done_gnt", bus.gnt, 3'b000);
        cycle(1'b0, 3'b001);
        check("single_idle_cnt", bus.cnt, 0);
        check("single_idle_state", bus.state_dbg, IDLE);
        cycle(1'b0, 3'b001);
        check("single_regrant", bus.gnt, 3'b001);

        // Round-robin with all requesting
        cycle(1'b1, 3'b000);
        done_seen = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, 3'b111);
            if (bus.state_dbg == RUN && bus.cnt == 2'd0) rr_owner.push_back(int'(bus.owner));
            if (bus.done) done_seen++;
        end
        check("rr_grants", rr_owner.size(), 4);
        if (rr_owner.size() == 4) begin
            check("rr_owner0", rr_owner[0], 0);
            check("rr_owner1", rr_owner[1], 1);
            check("rr_owner2", rr_owner[2], 2);
            check("rr_owner3", rr_owner[3], 0);
        end
        check("rr_dones", done_seen, 4);

        // Abort at cnt=1, then fairness moves past the aborted owner
        cycle(1'b1, 3'b000);
        cycle(1'b0, 3'b001);
        cycle(1'b0, 3'b001);
        check("abort_cnt1", bus.cnt, 1);
        cycle(1'b0, 3'b000);
        check("abort_gnt", bus.gnt, 3'b000);
        check("abort_cnt", bus.cnt, 0);
        check("abort_done", bus.done, 0);
        cycle(1'b0, 3'b011);
        check("abort_next_owner", bus.owner, 1);

        // Reset mid-run at cnt=2
        cycle(1'b0, 3'b011);
        cycle(1'b0, 3'b011);
        check("midrst_cnt2", bus.cnt, 2);
        cycle(1'b1, 3'b011);
        check("midrst_gnt", bus.gnt, 3'b000);
        check("midrst_cnt", bus.cnt, 0);
        check("midrst_busy", bus.busy, 0);
        cycle(1'b0, 3'b110);
        check("midrst_done", bus.done, 0);
        check("midrst_owner", bus.owner, 1);

        // Late arrival of req[2] during owner 0's DONE
        cycle(1'b1, 3'b000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'b001);
        check("late_in_done", bus.state_dbg, DONE);
        cycle(1'b0, 3'b101);
        cycle(1'b0, 3'b101);
        check("late_owner", bus.owner, 2);

        // Random traffic: requests mostly held, occasional changes and resets
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            rst = ($urandom_range(0, 63) == 0);
            cycle(rst, r);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
